mvau_inp_buf_ctrl: RTL
======================

// Module: mvau_inp_buf_ctrl
// PURPOSE
//  Sequences the MVAU input-activation buffer: ingests one SIMD-wide input vector of SF words
//  from the upstream stream while writing it into the buffer (output fold 0), then replays it
//  from the buffer for output folds 1..NF-1 with the upstream stalled. Sits between the input
//  stream, mvau_inp_buffer (wr_en/rd_en/addr) and the MVAU compute stage (out_v/out_rdy).
// PARAMETERS
//  SF        4   input folds per vector = MatrixW/SIMD; buffer words used (>=1)
//  NF        3   output folds per vector = MatrixH/PE; reuses per vector (>=1)
//  BUF_ADDR  16  buffer address width; SF <= 2**BUF_ADDR
// PORTS
//  clk       in   1         clock, all state updates on rising edge
//  rst_n     in   1         asynchronous, active-low reset
//  in_v      in   1         upstream activation word valid
//  in_rdy    out  1         upstream ready; word accepted when in_v & in_rdy
//  out_rdy   in   1         compute stage ready to consume a word
//  out_v     out  1         word presented to compute stage is valid
//  wr_en     out  1         buffer write enable
//  rd_en     out  1         buffer read select (1: buffer word, 0: pass-through stream)
//  addr      out  BUF_ADDR  buffer write/read address (= sf_cnt, zero-extended)
//  sf_last   out  1         current word is last input fold (sf_cnt == SF-1)
//  nf_last   out  1         current pass is last output fold (nf_cnt == NF-1)
//  vec_done  out  1         registered 1-cycle pulse after final word of the final fold fires
// BEHAVIOUR
//  State: st in {S_WRITE, S_READ}; counters sf_cnt [0..SF-1], nf_cnt [0..NF-1].
//  Reset (async, rst_n=0): st=S_WRITE, sf_cnt=0, nf_cnt=0, vec_done=0; while in reset and
//   after: in_rdy=out_rdy, out_v=in_v, wr_en=0 (asserts only once rst_n=1), rd_en=0, addr=0,
//   sf_last=(SF==1), nf_last=(NF==1).
//  Outputs (combinational from state, counters, handshakes; zero latency):
//   S_WRITE: in_rdy=out_rdy; out_v=in_v; rd_en=0; wr_en=in_v & out_rdy.
//   S_READ:  in_rdy=0; out_v=1; rd_en=1; wr_en=0.
//   addr=sf_cnt in both states.
//  fire = out_v & out_rdy (in S_WRITE this equals the upstream handshake).
//  On fire: sf_cnt = sf_last ? 0 : sf_cnt+1.
//   If sf_last: nf_cnt = nf_last ? 0 : nf_cnt+1.
//   Transitions (only on fire with sf_last):
//    S_WRITE -> S_READ if NF>1; stays S_WRITE if NF==1.
//    S_READ & nf_last -> S_WRITE; S_READ & !nf_last -> S_READ.
//   vec_done <= fire & sf_last & nf_last; else 0.
//  No fire -> all state held (stall on !in_v in S_WRITE or !out_rdy anywhere).
//  Word ordering per vector: NF passes of addr 0..SF-1; pass 0 from stream, passes 1..NF-1
//   from buffer; exactly SF upstream words accepted per NF*SF output words.
//  SF==1: addr constant 0, sf_last constant 1. NF==1: pure pass-through with buffer writes.
//  Back-to-back vectors: first word of next vector may fire the cycle after vec-final fire.
//  Reset mid-vector: partial vector discarded; next accepted word is word 0 of fold 0.
//  No overflow/underflow possible: writes only in S_WRITE, reads only addresses written
//   in the preceding S_WRITE pass.
// TESTING
//  T1 SF=4,NF=3, in_v/out_rdy held 1, words A0..A3 -> addr 0,1,2,3 x3, wr_en cycles 0-3,
//     rd_en cycles 4-11, in_rdy=0 cycles 4-11, vec_done=1 at cycle 12.
//  T2 T1 with in_v=0 on cycle 2 -> sf_cnt holds 2, wr_en=0, out_v=0 that cycle; A2 written next.
//  T3 out_rdy=0 for 3 cycles mid S_READ at addr 1 -> addr/rd_en held, nf_cnt unchanged, no skip.
//  T4 NF=1,SF=4: 8 words streamed -> rd_en never 1, in_rdy=out_rdy, vec_done after words 3 and 7.
//  T5 rst_n=0 async during S_READ nf_cnt=1 addr=2 -> immediately rd_en=0, addr=0, wr_en=0;
//     after release, next 4 words written to addr 0..3.
//  T6 SF=1,NF=2, two vectors back-to-back -> addr always 0, pattern W,R,W,R, vec_done after each R.

Source files
------------

// File: rtl/mvau_inp_buf_ctrl_if.sv
// Handshake and buffer-control bundle between the MVAU input-buffer
// sequencer, the upstream activation stream, the buffer and the compute stage.
interface mvau_inp_buf_ctrl_if #(
    parameter int BUF_ADDR = 16
);
    logic                in_v;
    logic                in_rdy;
    logic                out_rdy;
    logic                out_v;
    logic                wr_en;
    logic                rd_en;
    logic [BUF_ADDR-1:0] addr;
    logic                sf_last;
    logic                nf_last;
    logic                vec_done;

    // sequencer side
    modport master (
        input  in_v, out_rdy,
        output in_rdy, out_v, wr_en, rd_en, addr, sf_last, nf_last, vec_done
    );

    // environment side (stream source, buffer, compute stage)
    modport slave (
        output in_v, out_rdy,
        input  in_rdy, out_v, wr_en, rd_en, addr, sf_last, nf_last, vec_done
    );
endinterface

// File: rtl/mvau_inp_buf_ctrl.sv
// MVAU input-activation buffer sequencer. Fold 0 of every vector passes the
// upstream words straight through while writing them into the buffer; folds
// 1..NF-1 replay the same SF words from the buffer with the upstream stalled.
module mvau_inp_buf_ctrl #(
    parameter int SF       = 4,
    parameter int NF       = 3,
    parameter int BUF_ADDR = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    mvau_inp_buf_ctrl_if.master bus
);
    localparam int SFW = (SF > 1) ? $clog2(SF) : 1;
    localparam int NFW = (NF > 1) ? $clog2(NF) : 1;

    typedef enum logic {
        S_WRITE = 1'b0,
        S_READ  = 1'b1
    } st_t;

    st_t            r_st;
    st_t            w_st_nxt;
    logic [SFW-1:0] r_sf_cnt;
    logic [NFW-1:0] r_nf_cnt;
    logic           r_vec_done;

    logic           w_sf_last;
    logic           w_nf_last;
    logic           w_out_v;
    logic           w_fire;

    assign w_sf_last = (r_sf_cnt == SFW'(SF - 1));
    assign w_nf_last = (r_nf_cnt == NFW'(NF - 1));
    assign w_fire    = w_out_v & bus.out_rdy;

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_st <= S_WRITE;
        else        r_st <= w_st_nxt;
    end

    // next state: only the last word of a fold can change the pass type
    always_comb begin
        w_st_nxt = r_st;
        if (w_fire && w_sf_last) begin
            case (r_st)
                S_WRITE: if (NF > 1) w_st_nxt = S_READ;
                S_READ:  if (w_nf_last) w_st_nxt = S_WRITE;
                default: w_st_nxt = S_WRITE;
            endcase
        end
    end

    // outputs: write pass is a transparent stream, read passes self-source
    always_comb begin
        w_out_v    = bus.in_v;
        bus.in_rdy = bus.out_rdy;
        bus.rd_en  = 1'b0;
        // no buffer writes while held in reset even though the stream looks ready
        bus.wr_en  = bus.in_v & bus.out_rdy & rst_n;
        if (r_st == S_READ) begin
            w_out_v    = 1'b1;
            bus.in_rdy = 1'b0;
            bus.rd_en  = 1'b1;
            bus.wr_en  = 1'b0;
        end
    end

    assign bus.out_v    = w_out_v;
    assign bus.addr     = BUF_ADDR'(r_sf_cnt);
    assign bus.sf_last  = w_sf_last;
    assign bus.nf_last  = w_nf_last;
    assign bus.vec_done = r_vec_done;

    // fold counters advance per consumed word, wrapping at the fold ends
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sf_cnt <= '0;
            r_nf_cnt <= '0;
        end else if (w_fire) begin
            r_sf_cnt <= w_sf_last ? '0 : r_sf_cnt + SFW'(1);
            if (w_sf_last) r_nf_cnt <= w_nf_last ? '0 : r_nf_cnt + NFW'(1);
        end
    end

    // one-cycle pulse after the final word of the final fold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_vec_done <= 1'b0;
        else        r_vec_done <= w_fire & w_sf_last & w_nf_last;
    end
endmodule
